cmd_channel_ctrl: RTL and testbench
===================================

CMD_CHANNEL_CTRL -- requirements
Module: cmd_channel_ctrl

Interface
REQ-001 Parameter NUM_CH, default 4: number of controlled channels, legal range 1..26.
REQ-002 Parameter BASE_CHAR, default 8'h41 ("A"): ASCII code of channel 0; channel k is BASE_CHAR+k.
REQ-003 Parameter TIMEOUT_CYC, default 50000: maximum idle cycles allowed between first and second command byte.
REQ-004 Parameter PULSE_CYC, default 1000: high time, in cycles, of a pulse command; minimum 1.
REQ-005 clk  input  1  single clock; all logic is clocked on its rising edge.
REQ-006 rst  input  1  reset, synchronous, active-high.
REQ-007 po_data  input  8  received UART byte, valid only while rx_down=1.
REQ-008 rx_down  input  1  one-cycle strobe marking a new byte on po_data.
REQ-009 ch_state  output  NUM_CH  registered per-channel enable levels.
REQ-010 ack_valid  output  1  one-cycle strobe reporting a completed command attempt.
REQ-011 ack_ok  output  1  qualified by ack_valid: 1 = command executed, 0 = rejected.
REQ-012 ack_ch  output  5  qualified by ack_valid: channel index of the command; 0 on rejection.

Function
REQ-013 A command is two bytes: channel letter, then opcode "1" (set), "0" (clear), "T" (toggle) or "P" (pulse).
REQ-014 Parser FSM states: IDLE, GOT_CH; a captured channel index register is loaded on entry to GOT_CH.
REQ-015 IDLE: a byte in BASE_CHAR..BASE_CHAR+NUM_CH-1 moves the FSM to GOT_CH; any other byte is dropped silently with no ack.
REQ-016 GOT_CH with a valid opcode executes it, pulses ack_valid=1 with ack_ok=1 and ack_ch=index, and returns to IDLE.
REQ-017 GOT_CH with another valid channel letter is a resync: it replaces the captured index, stays in GOT_CH, and produces no ack.
REQ-018 GOT_CH with any other byte pulses ack_valid=1 with ack_ok=0 and returns to IDLE.
REQ-019 Timeout: in GOT_CH a counter increments each cycle without rx_down and reloads to 0 on every rx_down.
REQ-020 When the counter reaches TIMEOUT_CYC, the FSM returns to IDLE and pulses ack_valid=1 with ack_ok=0.
REQ-021 If rx_down and timeout expiry fall in the same cycle, the byte is processed and the timeout is ignored.
REQ-022 Latency: ch_state and the ack outputs update on the first rising edge after the cycle in which the opcode byte is presented.
REQ-023 Pulse: "P" sets the channel to 1 and loads its counter with PULSE_CYC; the channel drops to 0 on the edge where the counter reaches 0, so the pulse is exactly PULSE_CYC cycles high.
REQ-024 "P" on a channel that is already pulsing restarts its counter; no pulses are merged or queued.
REQ-025 "1", "0" or "T" on a pulsing channel cancels the pulse, and the opcode is applied to the channel's current value (1 during a pulse).
REQ-026 Channels are independent: a command changes only the addressed channel, and any number of pulse counters may run at once.
REQ-027 Channels with no command keep their ch_state value indefinitely.

Reset
REQ-028 While rst=1 at a clock edge: ch_state=0, ack_valid=0, ack_ok=0, ack_ch=0, FSM=IDLE, timeout counter=0, all pulse counters=0.
REQ-029 Reset in the middle of a command or pulse discards that activity; nothing is resumed after reset is released.
REQ-030 The first byte accepted after reset release is treated as a first byte in IDLE.

Structure
REQ-031 A shared package cmd_pkg holds the opcode constants "1", "0", "T", "P", the FSM state encoding and the ack code constants.
REQ-032 One sub-module, ch_pulse_gen, is instantiated once per channel and holds that channel's state bit and pulse counter.
REQ-033 Counter widths are $clog2 of their parameter plus 1; no counter wraps.

Verification
REQ-034 Send "A","1" then "A","0" -> ch_state[0]=1 then 0; two acks, each with ok=1 and ch=0; other channels stay 0.
REQ-035 Send "C","P" with PULSE_CYC=8 -> ch_state[2] high for exactly 8 cycles; send "C","P" again mid-pulse -> high time extends to 8 cycles after the second command.
REQ-036 Send "B","X" -> ack ok=0; send "B","D","1" -> resync, ch_state[3]=1, ch_state[1] unchanged, exactly one ack.
REQ-037 Send "A", then no byte for TIMEOUT_CYC cycles -> ack ok=0; a following "1" is dropped in IDLE with no ack.
REQ-038 Send "Z","1" and "E","1" with NUM_CH=4 -> no state change and no ack; send "A","T" twice -> ch_state[0] goes 1 then 0.
REQ-039 Assert rst for 1 cycle during a pulse and between the two bytes of a command -> all outputs 0, FSM in IDLE, and the next "A","1" works normally.

Source files
------------

// File: rtl/cmd_pkg.sv
`default_nettype none
// ============================================================================
// Module      : cmd_pkg
// Description : Opcode characters, parser states and ack codes shared by the
//               command channel controller and its per-channel generators.
// Revision    : 1.0 - initial release
// ============================================================================
package cmd_pkg;

    localparam logic [7:0] c_CHR_SET = 8'h31;  // "1"
    localparam logic [7:0] c_CHR_CLR = 8'h30;  // "0"
    localparam logic [7:0] c_CHR_TGL = 8'h54;  // "T"
    localparam logic [7:0] c_CHR_PLS = 8'h50;  // "P"

    localparam logic c_ACK_OK  = 1'b1;
    localparam logic c_ACK_REJ = 1'b0;

    typedef enum logic [1:0] {
        OP_SET = 2'd0,
        OP_CLR = 2'd1,
        OP_TGL = 2'd2,
        OP_PLS = 2'd3
    } op_e;

    typedef enum logic [0:0] {
        ST_IDLE   = 1'b0,
        ST_GOT_CH = 1'b1
    } state_e;

    function automatic logic is_opcode(input logic [7:0] b);
        return (b == c_CHR_SET) || (b == c_CHR_CLR) ||
               (b == c_CHR_TGL) || (b == c_CHR_PLS);
    endfunction

    function automatic op_e decode_op(input logic [7:0] b);
        op_e op;
        case (b)
            c_CHR_CLR: op = OP_CLR;
            c_CHR_TGL: op = OP_TGL;
            c_CHR_PLS: op = OP_PLS;
            default:   op = OP_SET;
        endcase
        return op;
    endfunction

endpackage
`default_nettype wire

// File: rtl/ch_pulse_gen.sv
`default_nettype none
// ============================================================================
// Module      : ch_pulse_gen
// Description : One channel: enable level plus a pulse down-counter.
// Revision    : 1.0 - initial release
// ============================================================================
module ch_pulse_gen
    import cmd_pkg::*;
#(
    parameter int PULSE_CYC = 1000
) (
    input  logic clk,
    input  logic rst,
    input  logic i_cmd_valid,
    input  op_e  i_op,
    output logic o_state
);

    localparam int                 c_CNT_W = $clog2(PULSE_CYC) + 1;
    localparam logic [c_CNT_W-1:0] c_LOAD  = c_CNT_W'(PULSE_CYC);
    localparam logic [c_CNT_W-1:0] c_ONE   = c_CNT_W'(1);

    logic               r_state_q;
    logic               w_state_d;
    logic [c_CNT_W-1:0] r_cnt_q;
    logic [c_CNT_W-1:0] w_cnt_d;

    // Any non-pulse opcode cancels a running pulse before applying itself.
    always_comb begin
        w_state_d = r_state_q;
        w_cnt_d   = r_cnt_q;
        if (i_cmd_valid) begin
            case (i_op)
                OP_SET: begin w_state_d = 1'b1;       w_cnt_d = '0;     end
                OP_CLR: begin w_state_d = 1'b0;       w_cnt_d = '0;     end
                OP_TGL: begin w_state_d = ~r_state_q; w_cnt_d = '0;     end
                OP_PLS: begin w_state_d = 1'b1;       w_cnt_d = c_LOAD; end
                default: ;
            endcase
        end else if (r_cnt_q != '0) begin
            w_cnt_d = r_cnt_q - c_ONE;
            if (r_cnt_q == c_ONE) begin
                w_state_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state_q <= 1'b0;
            r_cnt_q   <= '0;
        end else begin
            r_state_q <= w_state_d;
            r_cnt_q   <= w_cnt_d;
        end
    end

    assign o_state = r_state_q;

endmodule
`default_nettype wire

// File: rtl/cmd_channel_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : cmd_channel_ctrl
// Description : Two-byte UART command parser driving per-channel enables.
// Revision    : 1.0 - initial release
// ============================================================================
module cmd_channel_ctrl
    import cmd_pkg::*;
#(
    parameter int         NUM_CH      = 4,
    parameter logic [7:0] BASE_CHAR   = 8'h41,
    parameter int         TIMEOUT_CYC = 50000,
    parameter int         PULSE_CYC   = 1000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [7:0]        po_data,
    input  logic              rx_down,
    output logic [NUM_CH-1:0] ch_state,
    output logic              ack_valid,
    output logic              ack_ok,
    output logic [4:0]        ack_ch
);

    localparam int              c_TW     = $clog2(TIMEOUT_CYC) + 1;
    localparam logic [c_TW-1:0] c_T_LAST = c_TW'(TIMEOUT_CYC);
    localparam logic [c_TW-1:0] c_T_ONE  = c_TW'(1);

    state_e          r_state_q, w_state_d;
    logic [4:0]      r_idx_q, w_idx_d;
    logic [c_TW-1:0] r_tcnt_q, w_tcnt_d;
    logic            r_ack_valid_q, w_ack_valid_d;
    logic            r_ack_ok_q, w_ack_ok_d;
    logic [4:0]      r_ack_ch_q, w_ack_ch_d;

    logic            w_cmd_en;
    op_e             w_op;
    logic [8:0]      w_off;
    logic            w_is_ch;
    logic [c_TW-1:0] w_tcnt_inc;

    // 9-bit offset: bit 8 set means the byte is below BASE_CHAR.
    assign w_off      = {1'b0, po_data} - {1'b0, BASE_CHAR};
    assign w_is_ch    = !w_off[8] && (w_off < 9'(NUM_CH));
    assign w_op       = decode_op(po_data);
    assign w_tcnt_inc = r_tcnt_q + c_T_ONE;

    always_comb begin
        w_state_d     = r_state_q;
        w_idx_d       = r_idx_q;
        w_tcnt_d      = r_tcnt_q;
        w_ack_valid_d = 1'b0;
        w_ack_ok_d    = c_ACK_REJ;
        w_ack_ch_d    = 5'd0;
        w_cmd_en      = 1'b0;
        case (r_state_q)
            ST_IDLE: begin
                w_tcnt_d = '0;
                if (rx_down && w_is_ch) begin
                    w_state_d = ST_GOT_CH;
                    w_idx_d   = w_off[4:0];
                end
            end
            ST_GOT_CH: begin
                if (rx_down) begin
                    w_tcnt_d = '0;
                    if (is_opcode(po_data)) begin
                        w_cmd_en      = 1'b1;
                        w_ack_valid_d = 1'b1;
                        w_ack_ok_d    = c_ACK_OK;
                        w_ack_ch_d    = r_idx_q;
                        w_state_d     = ST_IDLE;
                    end else if (w_is_ch) begin
                        w_idx_d = w_off[4:0];
                    end else begin
                        w_ack_valid_d = 1'b1;
                        w_state_d     = ST_IDLE;
                    end
                end else if (w_tcnt_inc == c_T_LAST) begin
                    w_tcnt_d      = '0;
                    w_ack_valid_d = 1'b1;
                    w_state_d     = ST_IDLE;
                end else begin
                    w_tcnt_d = w_tcnt_inc;
                end
            end
            default: w_state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state_q     <= ST_IDLE;
            r_idx_q       <= 5'd0;
            r_tcnt_q      <= '0;
            r_ack_valid_q <= 1'b0;
            r_ack_ok_q    <= 1'b0;
            r_ack_ch_q    <= 5'd0;
        end else begin
            r_state_q     <= w_state_d;
            r_idx_q       <= w_idx_d;
            r_tcnt_q      <= w_tcnt_d;
            r_ack_valid_q <= w_ack_valid_d;
            r_ack_ok_q    <= w_ack_ok_d;
            r_ack_ch_q    <= w_ack_ch_d;
        end
    end

    for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
        ch_pulse_gen #(
            .PULSE_CYC (PULSE_CYC)
        ) u_gen (
            .clk         (clk),
            .rst         (rst),
            .i_cmd_valid (w_cmd_en && (r_idx_q == 5'(k))),
            .i_op        (w_op),
            .o_state     (ch_state[k])
        );
    end

    assign ack_valid = r_ack_valid_q;
    assign ack_ok    = r_ack_ok_q;
    assign ack_ch    = r_ack_ch_q;

endmodule
`default_nettype wire

// File: tb/tb_cmd_channel_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_cmd_channel_ctrl
// Description : Self-checking bench; expected acks are queued as bytes go in.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_cmd_channel_ctrl;

    localparam int c_NUM_CH  = 4;
    localparam int c_TIMEOUT = 20;
    localparam int c_PULSE   = 8;

    typedef struct packed {
        logic       ok;
        logic [4:0] ch;
    } ack_t;

    logic                clk;
    logic                rst;
    logic [7:0]          po_data;
    logic                rx_down;
    logic [c_NUM_CH-1:0] ch_state;
    logic                ack_valid;
    logic                ack_ok;
    logic [4:0]          ack_ch;

    ack_t exp_q[$];
    int   n_errors = 0;
    int   n_checks = 0;

    cmd_channel_ctrl #(
        .NUM_CH      (c_NUM_CH),
        .BASE_CHAR   (8'h41),
        .TIMEOUT_CYC (c_TIMEOUT),
        .PULSE_CYC   (c_PULSE)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .po_data   (po_data),
        .rx_down   (rx_down),
        .ch_state  (ch_state),
        .ack_valid (ack_valid),
        .ack_ok    (ack_ok),
        .ack_ch    (ack_ch)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Scoreboard: every ack the DUT emits must match the oldest queued one.
    always @(negedge clk) begin
        if (ack_valid === 1'b1) begin
            ack_t got, want;
            got = '{ok: ack_ok, ch: ack_ch};
            n_checks++;
            if (exp_q.size() == 0) begin
                n_errors++;
                $display("FAIL ack_unexpected: got ok=%0b ch=%0d, required no ack", ack_ok, ack_ch);
            end else begin
                want = exp_q.pop_front();
                if (got !== want) begin
                    n_errors++;
                    $display("FAIL ack_value: got ok=%0b ch=%0d, required ok=%0b ch=%0d",
                             got.ok, got.ch, want.ok, want.ch);
                end
            end
        end
    end

    task automatic send_byte(input logic [7:0] b);
        po_data = b;
        rx_down = 1'b1;
        @(negedge clk);
        rx_down = 1'b0;
        po_data = 8'h00;
    endtask

    task automatic expect_ack(input logic ok, input logic [4:0] ch);
        ack_t a;
        a = '{ok: ok, ch: ch};
        exp_q.push_back(a);
    endtask

    task automatic check_state(input string name, input logic [c_NUM_CH-1:0] want);
        n_checks++;
        if (ch_state !== want) begin
            n_errors++;
            $display("FAIL %s: ch_state=%b, required %b", name, ch_state, want);
        end
    endtask

    task automatic check_drained(input string name);
        @(negedge clk);
        n_checks++;
        if (exp_q.size() != 0) begin
            n_errors++;
            $display("FAIL %s: %0d acks missing, required 0", name, exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        n_checks++;
        if ({ch_state, ack_valid, ack_ok, ack_ch} !== '0) begin
            n_errors++;
            $display("FAIL reset_outputs: ch=%b v=%b ok=%b ch_idx=%0d, required all 0",
                     ch_state, ack_valid, ack_ok, ack_ch);
        end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_set_clear();
        expect_ack(1'b1, 5'd0);
        send_byte("A"); send_byte("1");
        check_state("set_a", 4'b0001);
        expect_ack(1'b1, 5'd0);
        send_byte("A"); send_byte("0");
        check_state("clear_a", 4'b0000);
        check_drained("set_clear_acks");
    endtask

    task automatic test_pulse();
        int n;
        expect_ack(1'b1, 5'd2);
        send_byte("C"); send_byte("P");
        n = 0;
        while (ch_state[2] === 1'b1 && n < 40) begin
            n++;
            @(negedge clk);
        end
        n_checks++;
        if (n != c_PULSE) begin
            n_errors++;
            $display("FAIL pulse_width: high %0d cycles, required %0d", n, c_PULSE);
        end
        check_state("pulse_end", 4'b0000);
        expect_ack(1'b1, 5'd2);
        send_byte("C"); send_byte("P");
        repeat (3) @(negedge clk);
        expect_ack(1'b1, 5'd2);
        send_byte("C"); send_byte("P");
        n = 0;
        while (ch_state[2] === 1'b1 && n < 40) begin
            n++;
            @(negedge clk);
        end
        n_checks++;
        if (n != c_PULSE) begin
            n_errors++;
            $display("FAIL pulse_restart: high %0d cycles after restart, required %0d", n, c_PULSE);
        end
        check_drained("pulse_acks");
    endtask

    task automatic test_reject_resync();
        expect_ack(1'b0, 5'd0);
        send_byte("B"); send_byte("X");
        check_state("reject_b", 4'b0000);
        expect_ack(1'b1, 5'd1);
        send_byte("B"); send_byte("1");
        expect_ack(1'b1, 5'd3);
        send_byte("B"); send_byte("D"); send_byte("1");
        check_state("resync_d", 4'b1010);
        check_drained("resync_acks");
        expect_ack(1'b1, 5'd1);
        send_byte("B"); send_byte("0");
        expect_ack(1'b1, 5'd3);
        send_byte("D"); send_byte("0");
        check_drained("resync_cleanup");
    endtask

    task automatic test_timeout();
        int n;
        expect_ack(1'b0, 5'd0);
        send_byte("A");
        n = 0;
        while (exp_q.size() != 0 && n < 100) begin
            @(negedge clk);
            n++;
        end
        n_checks++;
        if (n < c_TIMEOUT || n > c_TIMEOUT + 1) begin
            n_errors++;
            $display("FAIL timeout_delay: ack after %0d cycles, required %0d", n, c_TIMEOUT);
            exp_q.delete();
        end
        send_byte("1");
        repeat (3) @(negedge clk);
        check_state("timeout_drop", 4'b0000);
        // Opcode arriving on the very cycle the timeout would expire wins.
        expect_ack(1'b1, 5'd0);
        send_byte("A");
        repeat (c_TIMEOUT - 1) @(negedge clk);
        send_byte("1");
        check_state("timeout_edge", 4'b0001);
        expect_ack(1'b1, 5'd0);
        send_byte("A"); send_byte("0");
        check_drained("timeout_acks");
    endtask

    task automatic test_bad_channel();
        send_byte("Z"); send_byte("1");
        send_byte("E"); send_byte("1");
        send_byte("@"); send_byte("1");
        repeat (2) @(negedge clk);
        check_state("bad_channel", 4'b0000);
        expect_ack(1'b1, 5'd0);
        send_byte("A"); send_byte("T");
        check_state("toggle_1", 4'b0001);
        expect_ack(1'b1, 5'd0);
        send_byte("A"); send_byte("T");
        check_state("toggle_2", 4'b0000);
        check_drained("bad_channel_acks");
    endtask

    task automatic test_back_to_back();
        expect_ack(1'b1, 5'd0); expect_ack(1'b1, 5'd1);
        expect_ack(1'b1, 5'd2); expect_ack(1'b1, 5'd3);
        send_byte("A"); send_byte("1");
        send_byte("B"); send_byte("P");
        send_byte("C"); send_byte("1");
        send_byte("D"); send_byte("P");
        check_state("b2b_all", 4'b1111);
        expect_ack(1'b1, 5'd1);
        send_byte("B"); send_byte("0");
        repeat (c_PULSE) @(negedge clk);
        check_state("b2b_after", 4'b0101);
        expect_ack(1'b1, 5'd0);
        send_byte("A"); send_byte("0");
        expect_ack(1'b1, 5'd2);
        send_byte("C"); send_byte("0");
        check_drained("b2b_acks");
    endtask

    task automatic test_reset_mid();
        expect_ack(1'b1, 5'd2);
        send_byte("C"); send_byte("P");
        check_drained("mid_pulse_ack");
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        n_checks++;
        if ({ch_state, ack_valid, ack_ok, ack_ch} !== '0) begin
            n_errors++;
            $display("FAIL reset_mid_pulse: ch=%b v=%b, required 0", ch_state, ack_valid);
        end
        repeat (c_PULSE + 2) @(negedge clk);
        check_state("pulse_not_resumed", 4'b0000);
        send_byte("A");
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        send_byte("1");
        repeat (2) @(negedge clk);
        check_state("reset_mid_cmd", 4'b0000);
        expect_ack(1'b1, 5'd0);
        send_byte("A"); send_byte("1");
        check_state("after_reset_cmd", 4'b0001);
        check_drained("reset_mid_acks");
    endtask

    initial begin
        rst     = 1'b1;
        po_data = 8'h00;
        rx_down = 1'b0;
        @(negedge clk);
        test_reset();
        test_set_clear();
        test_pulse();
        test_reject_resync();
        test_timeout();
        test_bad_channel();
        test_back_to_back();
        test_reset_mid();
        repeat (3) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
